// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI responder (spi_slave_4byte) and its
//   input-conditioning sub-module (spi_sync_edge).
//
//   Contents:
//     ST_IDLE / ST_SHIFT / ST_HOLD  raw state encodings
//     spi_state_t                   FSM state type built on those encodings
//     spi_mode_t                    SPI mode, encoded {CPOL,CPHA}
//     SPI_MIN_OVERSAMPLE            minimum CLK_IN : SPI_CLK frequency ratio
//     mode_cpol / mode_cpha         field accessors for spi_mode_t
//     lead_edge / trail_edge        map raw SPI_CLK rise/fall onto the
//                                   leading/trailing edges of a mode
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_HOLD  = ST_HOLD
    } spi_state_t;

    // Mode number equals the {CPOL,CPHA} bit pair.
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_t;

    // CLK_IN must run at least this many times faster than SPI_CLK so that
    // every SPI_CLK phase survives the synchronizer with margin to spare.
    localparam int SPI_MIN_OVERSAMPLE = 8;

    function automatic logic mode_cpol(input spi_mode_t mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_t mode);
        return mode[0];
    endfunction

    // The leading edge leaves the idle level, the trailing edge returns to it.
    function automatic logic lead_edge(input logic cpol, input logic rise,
                                       input logic fall);
        return cpol ? fall : rise;
    endfunction

    function automatic logic trail_edge(input logic cpol, input logic rise,
                                        input logic fall);
        return cpol ? rise : fall;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   SYNC-deep flop synchronizer for one asynchronous SPI pin, followed by a
//   registered copy of the synchronized level.  Rise/fall strobes are one
//   clk cycle wide and line up with the cycle in which 'level' changes.
//
//   Parameters:
//     SYNC     synchronizer depth (>= 2)
//     RST_VAL  value loaded into every stage (and the edge history) on reset
//
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous, active-high reset
//     pin    in   raw asynchronous input
//     level  out  synchronized level
//     rise   out  one-cycle strobe on a synchronized 0->1 transition
//     fall   out  one-cycle strobe on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC    = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] chain;
    logic            prev;

    // NOTE: flop chains use non-blocking assignments so every stage samples
    // the value its neighbour held before this edge, not the one just written.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC-2:0], pin};
            prev  <= chain[SYNC-1];
        end
    end

    assign level = chain[SYNC-1];
    assign rise  =  level & ~prev;
    assign fall  = ~level &  prev;

endmodule

// File: rtl/spi_slave_4byte.sv
// -----------------------------------------------------------------------------
// spi_slave_4byte
//   SPI responder that exchanges one C-bit word in each direction per frame.
//   SPI_CLK, SPI_SS and MOSI are oversampled in the CLK_IN domain; the mode
//   (CPOL/CPHA) is captured when SS is asserted.  MOSI is received LSB-first,
//   MISO is transmitted MSB-first.
//
//   Build option:
//     SPI_SLAVE_MISO_TRISTATE_EN  defined: MISO floats (1'bz) while deselected
//                                 or in reset, for a shared MISO line.
//                                 undefined: MISO is driven 0 while deselected.
//
//   Parameters:
//     C     frame length in bits (2..32)
//     SYNC  synchronizer depth on SPI_CLK, SPI_SS, MOSI (>= 2)
//
//   Ports:
//     CLK_IN     in   system clock, >= 8x SPI_CLK
//     RST        in   synchronous, active-high reset
//     SPI_CLK    in   serial clock from master
//     SPI_SS     in   slave select, active low
//     MOSI       in   serial data from master
//     MISO       out  serial data to master
//     CPOL       in   idle clock level, captured at SS assertion
//     CPHA       in   0: sample on leading edge, 1: on trailing edge
//     tx_data    in   reply word for the next frame
//     tx_load    in   strobe writing tx_data into the holding register
//     tx_ready   out  holding register empty
//     rx_data    out  last complete received word
//     rx_valid   out  one-cycle pulse when rx_data updates
//     frame_err  out  one-cycle pulse on early SS release or surplus clocks
// -----------------------------------------------------------------------------
module spi_slave_4byte
    import spi_pkg::*;
#(
    parameter int C    = 32,
    parameter int SYNC = 2
) (
    input  logic         CLK_IN,
    input  logic         RST,
    input  logic         SPI_CLK,
    input  logic         SPI_SS,
    input  logic         MOSI,
    output logic         MISO,
    input  logic         CPOL,
    input  logic         CPHA,
    input  logic [C-1:0] tx_data,
    input  logic         tx_load,
    output logic         tx_ready,
    output logic [C-1:0] rx_data,
    output logic         rx_valid,
    output logic         frame_err
);

    localparam int             CW       = $clog2(C + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(C - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s;

    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (CLK_IN),
        .rst   (RST),
        .pin   (SPI_CLK),
        .level (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // SS resets to the *asserted* level: if RST hits mid-frame while the pin
    // is still low, no fall can be seen until SS has risen and fallen again,
    // so the remainder of the interrupted frame is ignored.
    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_ss (
        .clk   (CLK_IN),
        .rst   (RST),
        .pin   (SPI_SS),
        .level (ss_s),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (CLK_IN),
        .rst   (RST),
        .pin   (MOSI),
        .level (mosi_s),
        .rise  (),
        .fall  ()
    );

    // ------------------------------------------------------------------
    // Mode-dependent edge selection
    // ------------------------------------------------------------------
    spi_mode_t mode_q;
    logic      cpol_q, cpha_q;
    logic      lead, trail, sample_edge, shift_edge;

    assign cpol_q      = mode_cpol(mode_q);
    assign cpha_q      = mode_cpha(mode_q);
    assign lead        = lead_edge(cpol_q, sclk_rise, sclk_fall);
    assign trail       = trail_edge(cpol_q, sclk_rise, sclk_fall);
    assign sample_edge = cpha_q ? trail : lead;
    assign shift_edge  = cpha_q ? lead  : trail;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    spi_state_t    state, next_state;
    logic [CW-1:0] bit_cnt;
    logic          err_seen;     // a surplus-clock error was already flagged
    logic          skip_shift;   // CPHA=1: first shift edge carries no shift

    logic start, do_sample, shift_tick, frame_done, err;

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        do_sample  = 1'b0;
        shift_tick = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE: begin
                if (ss_fall) begin
                    start      = 1'b1;
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ss_rise) begin
                    err        = 1'b1;
                    next_state = S_IDLE;
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        frame_done = 1'b1;
                        next_state = S_HOLD;
                    end
                end else if (shift_edge) begin
                    shift_tick = 1'b1;
                end
            end
            S_HOLD: begin
                // In CPHA=0 the last trailing (shift) edge legitimately lands
                // here, so only a surplus sample edge counts as an error.
                if (ss_rise) begin
                    next_state = S_IDLE;
                end else if (sample_edge && !err_seen) begin
                    err = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [C-1:0] tx_shift, rx_shift, rx_next, hold_reg;

    assign rx_next = {mosi_s, rx_shift[C-1:1]};

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            mode_q     <= SPI_MODE0;
            bit_cnt    <= '0;
            err_seen   <= 1'b0;
            skip_shift <= 1'b0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            hold_reg   <= '0;
            tx_ready   <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= frame_done;
            frame_err <= err;

            if (start) begin
                mode_q     <= spi_mode_t'({CPOL, CPHA});
                bit_cnt    <= '0;
                err_seen   <= 1'b0;
                skip_shift <= CPHA;
                rx_shift   <= '0;
                tx_shift   <= tx_ready ? '0 : hold_reg;
            end

            if (do_sample) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + CW'(1);
            end

            if (frame_done) begin
                rx_data <= rx_next;
            end

            if (shift_tick) begin
                if (skip_shift) begin
                    skip_shift <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[C-2:0], 1'b0};
                end
            end

            if (err) begin
                err_seen <= 1'b1;
            end

            // A load coinciding with the frame capture wins the ready flag:
            // the capture above took the old word, the new one waits.
            if (tx_load) begin
                hold_reg <= tx_data;
                tx_ready <= 1'b0;
            end else if (start) begin
                tx_ready <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // MISO
    // ------------------------------------------------------------------
    logic drive;

    assign drive = (state != S_IDLE) && !ss_s && !RST;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = drive ? tx_shift[C-1] : 1'bz;
`else
    assign MISO = drive ? tx_shift[C-1] : 1'b0;
`endif

endmodule
